// File: rtl/uart_pkg.sv
// uart_pkg: shared types and elaboration helpers for uart_buffered_controller.
// The PARITY engine state exists only when UART_PARITY_EN is defined.
package uart_pkg;

  // Engine state shared by the transmit and receive sequencers.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } engine_state_e;

  // Clock cycles per serial bit (truncated integer ratio).
  function automatic int uart_divisor(input longint clk_freq, input longint baud_rate);
    return int'(clk_freq / baud_rate);
  endfunction

  // Width needed to hold a fill level of 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: single-clock FIFO with fill level. Push on full and pop on
// empty are ignored; push and pop in the same cycle both take effect.
module uart_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              pop_data,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Show-ahead read: the head entry is visible before it is popped.
  assign pop_data = mem[rd_ptr];

  // Storage write.
  // NOTE: the array is deliberately left out of reset; only pointers and the
  // count need a known state, and an unreset array can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and fill-level bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_controller.sv
// uart_buffered_controller: UART with one FIFO per direction and a
// request/acknowledge character interface. Define UART_PARITY_EN to add a
// parity bit (even, or odd with PARITY_ODD=1) and live rx_parity_err.
module uart_buffered_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               rx_data_req,
  output logic [DATA_BITS-1:0]               rx_data,
  output logic                               rx_data_ack,
  input  logic                               tx_data_req,
  input  logic [DATA_BITS-1:0]               tx_data,
  output logic                               tx_data_ack,
  output logic [count_width(FIFO_DEPTH)-1:0] rx_count,
  output logic [count_width(FIFO_DEPTH)-1:0] tx_count,
  output logic                               rx_overrun,
  output logic                               rx_frame_err,
  output logic                               rx_parity_err,
  input  logic                               rx_pin,
  output logic                               tx_pin
);

  localparam int DIVISOR = uart_divisor(CLK_FREQ, BAUD_RATE);
  localparam int DIV_W   = $clog2(DIVISOR);
  localparam int BIT_W   = $clog2(DATA_BITS);

  // Reject parameter sets the engines cannot honour.
  if (DIVISOR < 4 || DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_buffered_controller: unsupported parameter set");
  end

`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
`endif

  // ---------------------------------------------------------------- FIFOs
  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] tx_fifo_dout, rx_fifo_dout, rx_shift;

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_fifo_dout),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .pop_data  (rx_fifo_dout),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // ----------------------------------------------------------- handshakes
  // A pending ack blocks the next transfer, so a held request moves one
  // character every two cycles.
  assign tx_push = tx_data_req && !tx_data_ack && !tx_full;
  assign rx_pop  = rx_data_req && !rx_data_ack && !rx_empty;

  // Registered acknowledges, one cycle after the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data_ack <= 1'b0;
      rx_data_ack <= 1'b0;
      rx_data     <= '0;
    end else begin
      tx_data_ack <= tx_push;
      rx_data_ack <= rx_pop;
      if (rx_pop) rx_data <= rx_fifo_dout;
    end
  end

  // ------------------------------------------------------------ TX engine
  engine_state_e        tx_state;
  logic [DIV_W-1:0]     tx_cnt;
  logic [DATA_BITS-1:0] tx_shift;
  logic [BIT_W-1:0]     tx_bit;
  logic                 tx_stop;
  logic                 tx_tick;
`ifdef UART_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_tick = (tx_cnt == DIV_W'(DIVISOR - 1));
  assign tx_pop  = (tx_state == IDLE) && en && !tx_empty;

  // Transmit sequencer: each line level is held for exactly DIVISOR cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_stop  <= 1'b0;
      tx_pin   <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_cnt <= (tx_state == IDLE || tx_tick) ? '0 : tx_cnt + DIV_W'(1);
      case (tx_state)
        IDLE: begin
          tx_pin <= 1'b1;
          if (tx_pop) begin
            tx_shift <= tx_fifo_dout;
`ifdef UART_PARITY_EN
            tx_par   <= (^tx_fifo_dout) ^ PAR_ODD;
`endif
            tx_pin   <= 1'b0;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_tick) begin
            tx_pin   <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= '0;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_tick) begin
            if (tx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              tx_pin   <= tx_par;
              tx_state <= PARITY;
`else
              tx_pin   <= 1'b1;
              tx_stop  <= 1'b0;
              tx_state <= STOP;
`endif
            end else begin
              tx_pin   <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + BIT_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (tx_tick) begin
            tx_pin   <= 1'b1;
            tx_stop  <= 1'b0;
            tx_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (tx_tick) begin
            if (tx_stop == 1'(STOP_BITS - 1)) tx_state <= IDLE;
            else                              tx_stop  <= 1'b1;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------ RX engine
  logic rx_meta, rx_sync, rx_prev;

  // Two-flop synchroniser for the asynchronous line, plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  engine_state_e    rx_state;
  logic [DIV_W-1:0] rx_cnt;
  logic [BIT_W-1:0] rx_bit;
  logic             rx_tick, rx_half, rx_stop_sample;
`ifdef UART_PARITY_EN
  logic             rx_par_bit;
`endif

  assign rx_tick        = (rx_cnt == DIV_W'(DIVISOR - 1));
  assign rx_half        = (rx_cnt == DIV_W'(DIVISOR / 2 - 1));
  assign rx_stop_sample = (rx_state == STOP) && rx_tick;
  // A good stop bit writes the character at this edge, so the count moves next cycle.
  assign rx_push        = rx_stop_sample && rx_sync && !rx_full;

  // Receive sequencer: validate the start bit at mid-bit, then sample every DIVISOR cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state     <= IDLE;
      rx_cnt       <= '0;
      rx_shift     <= '0;
      rx_bit       <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_bit    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_cnt <= (rx_state == IDLE || rx_tick || (rx_state == START && rx_half))
                ? '0 : rx_cnt + DIV_W'(1);
      rx_frame_err <= rx_stop_sample && !rx_sync;
      rx_overrun   <= rx_stop_sample && rx_sync && rx_full;
`ifdef UART_PARITY_EN
      rx_parity_err <= rx_push && (rx_par_bit != ((^rx_shift) ^ PAR_ODD));
`endif
      case (rx_state)
        IDLE: begin
          if (en && rx_prev && !rx_sync) rx_state <= START;
        end
        START: begin
          if (rx_half) begin
            if (rx_sync) begin
              rx_state <= IDLE;
            end else begin
              rx_bit   <= '0;
              rx_state <= DATA;
            end
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              rx_state <= PARITY;
`else
              rx_state <= STOP;
`endif
            end else begin
              rx_bit <= rx_bit + BIT_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        PARITY: begin
          if (rx_tick) begin
            rx_par_bit <= rx_sync;
            rx_state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (rx_tick) rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule
